// File: rtl/box_plot_pkg.sv
// box_plot_pkg: shared state encoding, coordinate widths and screen limits for the box plotter.
package box_plot_pkg;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int SCR_X_MAX = 159;
  localparam int SCR_Y_MAX = 119;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/box_plot_counter.sv
// box_plot_counter: 2-D raster dx/dy counter with runtime wrap limits and a last-pixel flag.
module box_plot_counter
  import box_plot_pkg::*;
#(
  parameter int DXW = XW,
  parameter int DYW = YW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr_i,
  input  logic           en_i,
  input  logic [DXW-1:0] x_last_i,
  input  logic [DYW-1:0] y_last_i,
  output logic [DXW-1:0] dx_o,
  output logic [DYW-1:0] dy_o,
  output logic           last_o
);
  logic [DXW-1:0] dx_q, dx_d;
  logic [DYW-1:0] dy_q, dy_d;
  logic           x_end;
  assign x_end  = dx_q == x_last_i;
  assign last_o = x_end && dy_q == y_last_i;
  always_comb begin
    dx_d = clr_i ? '0 : en_i ? (x_end ? '0 : dx_q + 1'b1) : dx_q;
    dy_d = clr_i ? '0 : (en_i && x_end) ? (last_o ? '0 : dy_q + 1'b1) : dy_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end
  assign dx_o = dx_q;
  assign dy_o = dy_q;
endmodule

// File: rtl/box_plot_fsm.sv
// box_plot_fsm: walks a BOX_W x BOX_H rectangle one clipped pixel per clock for the VGA datapath.
// Defining BOX_PLOT_CLEAR_EN adds a clear input that sweeps the whole screen in black.
module box_plot_fsm
  import box_plot_pkg::*;
#(
  parameter int BOX_W = 4,
  parameter int BOX_H = 4,
  parameter int X_MAX = SCR_X_MAX,
  parameter int Y_MAX = SCR_Y_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
`ifdef BOX_PLOT_CLEAR_EN
  input  logic          clear,
`endif
  input  logic [XW-1:0] x_origin,
  input  logic [YW-1:0] y_origin,
  input  logic [CW-1:0] colour,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [CW-1:0] colour_out,
  output logic          plot
);
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;
  localparam logic [XW-1:0] BX_LAST = XW'(BOX_W - 1);
  localparam logic [YW-1:0] BY_LAST = YW'(BOX_H - 1);
  localparam logic [XW1-1:0] X_LIM = XW1'(X_MAX);
  localparam logic [YW1-1:0] Y_LIM = YW1'(Y_MAX);
  state_t        state_q, state_d;
  logic [XW-1:0] x0_q, x0_d, x_q, x_d, dx, lim_x, org_x;
  logic [YW-1:0] y0_q, y0_d, y_q, y_d, dy, lim_y, org_y;
  logic [CW-1:0] c0_q, c0_d, c_q, c_d, org_c;
  logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic          go, accept, draw, last, clip;
  logic [XW:0]   xs;
  logic [YW:0]   ys;
`ifdef BOX_PLOT_CLEAR_EN
  localparam logic [XW-1:0] SX_LAST = XW'(X_MAX);
  localparam logic [YW-1:0] SY_LAST = YW'(Y_MAX);
  logic clr_q, clr_d;
  assign go    = start | clear;
  assign clr_d = accept ? clear : clr_q;
  assign lim_x = clr_q ? SX_LAST : BX_LAST;
  assign lim_y = clr_q ? SY_LAST : BY_LAST;
  assign org_x = clear ? '0 : x_origin;
  assign org_y = clear ? '0 : y_origin;
  assign org_c = clear ? '0 : colour;
  always_ff @(posedge clk) begin
    if (reset) clr_q <= 1'b0;
    else clr_q <= clr_d;
  end
`else
  assign go    = start;
  assign lim_x = BX_LAST;
  assign lim_y = BY_LAST;
  assign org_x = x_origin;
  assign org_y = y_origin;
  assign org_c = colour;
`endif
  // done_q marks the IDLE cycle that carries the done pulse; a request there is refused.
  assign accept = state_q == S_IDLE && go && !done_q;
  assign draw   = state_q == S_DRAW;
  assign xs     = {1'b0, x0_q} + {1'b0, dx};
  assign ys     = {1'b0, y0_q} + {1'b0, dy};
  assign clip   = xs > X_LIM || ys > Y_LIM;
  box_plot_counter #(.DXW(XW), .DYW(YW)) u_cnt (
    .clk      (clk),
    .rst      (reset),
    .clr_i    (accept),
    .en_i     (draw),
    .x_last_i (lim_x),
    .y_last_i (lim_y),
    .dx_o     (dx),
    .dy_o     (dy),
    .last_o   (last)
  );
  always_comb begin
    state_d = accept ? S_DRAW : draw ? (last ? S_DONE : S_DRAW) : S_IDLE;
    x0_d    = accept ? org_x : x0_q;
    y0_d    = accept ? org_y : y0_q;
    c0_d    = accept ? org_c : c0_q;
    x_d     = draw ? xs[XW-1:0] : x_q;
    y_d     = draw ? ys[YW-1:0] : y_q;
    c_d     = draw ? c0_q : c_q;
    plot_d  = draw && !clip;
    busy_d  = draw;
    done_d  = state_q == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      c0_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      c0_q    <= c0_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy       = busy_q;
  assign done       = done_q;
  assign plot       = plot_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = c_q;
endmodule

// File: tb/tb_box_plot_fsm.sv
// tb_box_plot_fsm: directed and randomized box draws checked against a raster/clipping model.
module tb_box_plot_fsm;
  localparam int BW = 4;
  localparam int BH = 4;
  localparam int XM = 159;
  localparam int YM = 119;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x_origin = '0;
  logic [6:0] y_origin = '0;
  logic [2:0] colour = '0;
`ifdef BOX_PLOT_CLEAR_EN
  logic       clear = 1'b0;
`endif
  logic       busy, done, plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  int checks = 0;
  int errors = 0;

  box_plot_fsm #(.BOX_W(BW), .BOX_H(BH), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef BOX_PLOT_CLEAR_EN
    .clear      (clear),
`endif
    .x_origin   (x_origin),
    .y_origin   (y_origin),
    .colour     (colour),
    .busy       (busy),
    .done       (done),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a request at a negedge and return at the negedge right after it is accepted.
  task automatic launch(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    start = 1'b1;
    x_origin = x;
    y_origin = y;
    colour = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Model: pixel k of the box is (x + k%BW, y + k/BW); it is plotted only if on screen.
  task automatic expect_box(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                            input bit perturb);
    for (int k = 0; k < BW * BH; k++) begin
      int wx, wy;
      bit ep;
      @(negedge clk);
      if (perturb && k == 2) begin
        colour = 3'b010;
        y_origin = '0;
        x_origin = x + 8'd33;
      end
      wx = int'(x) + k % BW;
      wy = int'(y) + k / BW;
      ep = (wx <= XM) && (wy <= YM);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("plot", plot, 32'(ep));
      if (ep) begin
        chk("x_out", x_out, wx);
        chk("y_out", y_out, wy);
        chk("colour_out", colour_out, c);
      end
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("plot_end", plot, 0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", plot, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_c", colour_out, 0);
    reset = 1'b0;

    launch(8'd10, 7'd20, 3'b100);
    expect_box(8'd10, 7'd20, 3'b100, 1'b0);

    launch(8'd158, 7'd118, 3'b111);
    expect_box(8'd158, 7'd118, 3'b111, 1'b0);

    launch(8'd10, 7'd20, 3'b100);
    expect_box(8'd10, 7'd20, 3'b100, 1'b1);

    launch(8'd30, 7'd40, 3'b001);
    start = 1'b1;
    x_origin = 8'd50;
    expect_box(8'd30, 7'd40, 3'b001, 1'b0);
    @(negedge clk);
    chk("hold_done_cycle_busy", busy, 0);
    chk("hold_done_cycle_plot", plot, 0);
    chk("hold_done_cycle_done", done, 0);
    @(negedge clk);
    chk("hold_accept_busy", busy, 0);
    chk("hold_accept_plot", plot, 0);
    start = 1'b0;
    expect_box(8'd50, 7'd40, 3'b001, 1'b0);

    launch(8'd250, 7'd125, 3'b011);
    expect_box(8'd250, 7'd125, 3'b011, 1'b0);

    for (int i = 0; i < 12; i++) begin
      logic [7:0] rx;
      logic [6:0] ry;
      logic [2:0] rc;
      rx = 8'($urandom_range(0, 255));
      ry = 7'($urandom_range(0, 127));
      rc = 3'($urandom_range(0, 7));
      if (i % 4 == 1) begin
        rx = 8'($urandom_range(150, 165));
        ry = 7'($urandom_range(110, 125));
      end
      launch(rx, ry, rc);
      expect_box(rx, ry, rc, i % 3 == 0);
    end

    launch(8'd20, 7'd30, 3'b101);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_plot", plot, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_x", x_out, 0);
    chk("abort_y", y_out, 0);
    chk("abort_c", colour_out, 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || plot || busy) seen = 1'b1;
    end
    chk("abort_quiet", 32'(seen), 0);

    launch(8'd0, 7'd0, 3'b111);
    expect_box(8'd0, 7'd0, 3'b111, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
